// File: rtl/servo_motion_ctrl.sv
// Servo motion sequencer: accepts clamped pulse-width targets over valid/ready and ramps the
// PWM angle toward them by at most STEP clock cycles of pulse width per servo frame.
module servo_motion_ctrl #(
  parameter int unsigned FRAME_CYCLES = 2_000_000,
  parameter int unsigned MIN_PW       = 50_000,
  parameter int unsigned MAX_PW       = 250_000,
  parameter int unsigned HOME_PW      = 150_000,
  parameter int unsigned STEP         = 1_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        abort,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_target,
  output logic        pwm_en,
  output logic [23:0] pwm_angle,
  output logic        busy,
  output logic        done,
  output logic        frame_tick
);

  localparam int unsigned CntW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_CYCLES - 1);
  localparam logic [23:0] MinPw  = 24'(MIN_PW);
  localparam logic [23:0] MaxPw  = 24'(MAX_PW);
  localparam logic [23:0] HomePw = 24'(HOME_PW);
  localparam logic [24:0] StepW  = 25'(STEP);

  typedef enum logic [1:0] {StOff, StHold, StMove} state_t;

  state_t            state_q, state_d;
  logic [CntW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [23:0]       angle_q, angle_d;
  logic [23:0]       target_q, target_d;
  logic              done_q, done_d;

  logic [23:0]       cmd_clamped;
  logic signed [24:0] diff;
  logic [24:0]       mag;
  logic [23:0]       step_amt;
  logic [23:0]       stepped;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StOff;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: position, target, frame counter and the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angle_q     <= HomePw;
      target_q    <= HomePw;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      angle_q     <= angle_d;
      target_q    <= target_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
    end
  end

  // Clamp incoming commands and compute the bounded per-frame step toward the target
  always_comb begin
    if (cmd_target < MinPw) begin
      cmd_clamped = MinPw;
    end else if (cmd_target > MaxPw) begin
      cmd_clamped = MaxPw;
    end else begin
      cmd_clamped = cmd_target;
    end
    diff     = $signed({1'b0, target_q}) - $signed({1'b0, angle_q});
    mag      = diff[24] ? $unsigned(-diff) : $unsigned(diff);
    step_amt = (mag > StepW) ? StepW[23:0] : mag[23:0];
    stepped  = diff[24] ? (angle_q - step_amt) : (angle_q + step_amt);
  end

  // Next-state logic; enable=0 outranks abort, which outranks commands and frame ticks
  always_comb begin
    state_d  = state_q;
    angle_d  = angle_q;
    target_d = target_q;
    done_d   = 1'b0;
    unique case (state_q)
      StOff: begin
        if (enable) state_d = StHold;
      end
      StHold: begin
        if (!enable) begin
          state_d  = StOff;
          target_d = angle_q;
        end else if (cmd_valid) begin
          target_d = cmd_clamped;
          if (cmd_clamped == angle_q) begin
            done_d = 1'b1;
          end else begin
            state_d = StMove;
          end
        end
      end
      StMove: begin
        if (!enable) begin
          state_d  = StOff;
          target_d = angle_q;
        end else if (abort) begin
          state_d  = StHold;
          target_d = angle_q;
        end else if (frame_tick) begin
          angle_d = stepped;
          if (stepped == target_q) begin
            state_d = StHold;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StOff;
    endcase

    // Counter sits at zero while off so a fresh enable starts a full frame
    if (state_q == StOff || state_d == StOff) begin
      frame_cnt_d = '0;
    end else if (frame_cnt_q == LastCnt) begin
      frame_cnt_d = '0;
    end else begin
      frame_cnt_d = frame_cnt_q + CntW'(1);
    end
  end

  // Outputs; cmd_ready also drops with enable so a handshake is never silently discarded
  always_comb begin
    pwm_en     = (state_q != StOff);
    cmd_ready  = (state_q == StHold) && enable;
    busy       = (state_q == StMove);
    frame_tick = (state_q != StOff) && (frame_cnt_q == LastCnt);
    done       = done_q;
    pwm_angle  = angle_q;
  end

endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Bench for servo_motion_ctrl: directed scenarios plus randomized traffic, every cycle checked
// against a behavioural model of the controller.
module tb_servo_motion_ctrl;

  localparam int FC   = 100;
  localparam int STP  = 1000;
  localparam int MINP = 50_000;
  localparam int MAXP = 250_000;
  localparam int HOME = 150_000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        abort;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_target;
  logic        pwm_en;
  logic [23:0] pwm_angle;
  logic        busy;
  logic        done;
  logic        frame_tick;

  servo_motion_ctrl #(
    .FRAME_CYCLES(FC),
    .MIN_PW      (MINP),
    .MAX_PW      (MAXP),
    .HOME_PW     (HOME),
    .STEP        (STP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .abort     (abort),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_target(cmd_target),
    .pwm_en    (pwm_en),
    .pwm_angle (pwm_angle),
    .busy      (busy),
    .done      (done),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Behavioural model: servo driven?, move in progress?, position, goal, frame phase, done pulse
  bit m_on;
  bit m_mv;
  bit m_done;
  int m_angle;
  int m_target;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v < MINP) return MINP;
    if (v > MAXP) return MAXP;
    return v;
  endfunction

  task automatic model_reset();
    m_on = 0; m_mv = 0; m_done = 0; m_angle = HOME; m_target = HOME; m_cnt = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    bit tick;
    int d, s;
    tick = m_on && (m_cnt == FC - 1);
    m_done = 0;
    if (!m_on) begin
      if (enable) begin
        m_on = 1; m_cnt = 0;
      end
    end else if (!enable) begin
      m_on = 0; m_mv = 0; m_target = m_angle; m_cnt = 0;
    end else begin
      if (m_mv) begin
        if (abort) begin
          m_mv = 0; m_target = m_angle;
        end else if (tick) begin
          d = m_target - m_angle;
          s = (d < 0) ? -d : d;
          if (s > STP) s = STP;
          m_angle = (d < 0) ? m_angle - s : m_angle + s;
          if (m_angle == m_target) begin
            m_mv = 0; m_done = 1;
          end
        end
      end else if (cmd_valid) begin
        m_target = clamp(int'(cmd_target));
        if (m_target == m_angle) m_done = 1;
        else m_mv = 1;
      end
      m_cnt = (m_cnt + 1) % FC;
    end
  endtask

  // Called at posedge+1 with inputs already driven; checks outputs, then advances one clock
  task automatic cycle(output bit acc);
    #1;
    check("pwm_en", pwm_en, m_on);
    check("busy", busy, m_mv);
    check("done", done, m_done);
    check("cmd_ready", cmd_ready, m_on && !m_mv && enable);
    check("frame_tick", frame_tick, m_on && (m_cnt == FC - 1));
    check("pwm_angle", pwm_angle, m_angle);
    acc = m_on && !m_mv && enable && cmd_valid;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic send(input int tgt);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    cmd_valid = 1;
    cmd_target = 24'(tgt);
    while (!acc && n < 2000) begin
      cycle(acc);
      n++;
    end
    cmd_valid = 0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit acc;
    int n;
    n = 0;
    while ((busy || m_mv) && n < budget) begin
      cycle(acc);
      n++;
    end
    if (n >= budget) check("idle_timeout", 0, 1);
    run(2);
  endtask

  initial begin
    bit acc;
    int n;
    int t;

    rst = 1; enable = 0; abort = 0; cmd_valid = 0; cmd_target = '0;
    model_reset();
    #2;
    check("rst_angle", pwm_angle, HOME);
    check("rst_en", pwm_en, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tick", frame_tick, 0);
    @(posedge clk);
    #1;
    rst = 0;
    run(3);

    // Enable, watch a few frames pass in HOLD
    enable = 1;
    run(250);
    check("hold_ready", cmd_ready, 1);

    // Short ramp ending with a partial step
    send(155_500);
    wait_idle(2000);
    check("ramp_end", pwm_angle, 155_500);

    // Out-of-range commands clamp to the legal limits
    send(10_000);
    wait_idle(20_000);
    check("clamp_lo", pwm_angle, MINP);
    send(400_000);
    wait_idle(30_000);
    check("clamp_hi", pwm_angle, MAXP);

    // Command equal to present position: done without moving
    send(MAXP);
    check("eq_busy", busy, 0);
    run(3);
    check("eq_angle", pwm_angle, MAXP);

    // Abort after three frames of a ramp from home
    send(HOME);
    wait_idle(20_000);
    send(200_000);
    n = 0;
    while (m_angle != 153_000 && n < 1000) begin
      cycle(acc);
      n++;
    end
    abort = 1;
    cycle(acc);
    abort = 0;
    run(5);
    check("abort_angle", pwm_angle, 153_000);
    check("abort_ready", cmd_ready, 1);

    // Abort landing on a frame tick discards that tick's step
    send(160_000);
    n = 0;
    while (m_cnt != FC - 1 && n < 1000) begin
      cycle(acc);
      n++;
    end
    abort = 1;
    cycle(acc);
    abort = 0;
    run(3);
    check("abort_tick_angle", pwm_angle, 153_000);

    // Disable mid-move, then re-enable
    send(170_000);
    run(150);
    enable = 0;
    run(10);
    check("off_en", pwm_en, 0);
    enable = 1;
    run(250);

    // Asynchronous reset mid-move
    send(190_000);
    run(120);
    #2;
    rst = 1;
    #1;
    check("arst_angle", pwm_angle, HOME);
    check("arst_en", pwm_en, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", cmd_ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    run(5);

    // Randomized traffic, valid held until accepted
    for (int i = 0; i < 20_000; i++) begin
      enable = ($urandom_range(0, 199) != 0);
      abort  = ($urandom_range(0, 299) == 0);
      if (!cmd_valid && $urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          t = int'($urandom_range(0, 300_000));
        end else begin
          t = m_angle + int'($urandom_range(0, 6000)) - 3000;
          if (t < 0) t = 0;
        end
        cmd_valid  = 1;
        cmd_target = 24'(t);
      end
      cycle(acc);
      if (acc) cmd_valid = 0;
    end
    cmd_valid = 0;
    abort = 0;
    run(5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
